// File: rtl/song_scheduler_if.sv
// Bus between the song scheduler and its surroundings. It carries the
// debounced buttons, the song start-address table, the score ROM and the
// tone generator outputs.
//   master : environment side (drives commands, table and ROM data)
//   slave  : scheduler side (drives ROM address, song index and note outputs)
interface song_scheduler_if #(
    parameter int SONG_W = 3
);
    logic              cmd_play;
    logic              cmd_next;
    logic              cmd_prev;
    logic              repeat_mode;
    logic [SONG_W-1:0] song_last;
    logic [15:0]       song_base;
    logic [15:0]       rom_addr;
    logic [11:0]       rom_data;
    logic [SONG_W-1:0] song_sel;
    logic              note_valid;
    logic [3:0]        note_idx;
    logic [2:0]        note_band;
    logic              playing;
    logic              song_done;

    modport master (
        output cmd_play, cmd_next, cmd_prev, repeat_mode, song_last, song_base, rom_data,
        input  rom_addr, song_sel, note_valid, note_idx, note_band, playing, song_done
    );

    modport slave (
        input  cmd_play, cmd_next, cmd_prev, repeat_mode, song_last, song_base, rom_data,
        output rom_addr, song_sel, note_valid, note_idx, note_band, playing, song_done
    );
endinterface

// File: rtl/song_scheduler.sv
// Music box playback sequencer. It walks the score ROM, times each note with
// a duration counter and drives note_idx/note_band/note_valid to the tone
// generator. It also handles next/prev song select, play/pause, end-of-song
// and repeat.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : song_scheduler_if.slave. Its inputs are the commands,
//                repeat_mode, song_last, song_base and rom_data. Its outputs
//                are rom_addr, song_sel, note_valid, note_idx, note_band,
//                playing and song_done.
module song_scheduler #(
    parameter int TICKS_PER_UNIT = 6_250_000,
    parameter int GAP_TICKS      = 250_000,
    parameter int ROM_LAT        = 1,
    parameter int SONG_W         = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    song_scheduler_if.slave bus
);
    localparam logic [2:0] S_STOP  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;

    localparam logic [27:0] TPU = 28'(TICKS_PER_UNIT);
    localparam logic [27:0] GAP = 28'(GAP_TICKS);
    localparam logic [1:0]  LAT = 2'(ROM_LAT);

    logic [2:0]        state, nxt, saved, load_go;
    logic [27:0]       cnt;
    logic [1:0]        wait_cnt;
    logic [15:0]       addr;
    logic [SONG_W-1:0] sel, sel_next, sel_prev;
    logic [3:0]        idx;
    logic [2:0]        band;
    logic              done;
    logic              running, sample;
    logic [4:0]        dur;

    assign running = (state == S_FETCH) || (state == S_PLAY) || (state == S_GAP);
    assign sample  = (state == S_FETCH) && (wait_cnt == LAT);
    assign dur     = bus.rom_data[4:0];

    // An out-of-range index (song_last shrank under us) falls back to song 0.
    assign sel_next = (sel >= bus.song_last) ? '0 : sel + SONG_W'(1);
    assign sel_prev = (sel > bus.song_last) ? '0 :
                      (sel == '0)           ? bus.song_last : sel - SONG_W'(1);

    // Where a running state goes this cycle. A pause saves this value
    // rather than the current state, so the cycle spent before the pause
    // still counts toward the note length.
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: if (sample) nxt = (dur == 5'd0) ? (bus.repeat_mode ? S_LOAD : S_STOP) : S_PLAY;
            S_PLAY:  if (cnt == GAP) nxt = (GAP == 28'd0) ? S_FETCH : S_GAP;
            S_GAP:   if (cnt == 28'd0) nxt = S_FETCH;
            default: nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_STOP;
            saved    <= S_STOP;
            load_go  <= S_STOP;
            cnt      <= '0;
            wait_cnt <= '0;
            addr     <= '0;
            sel      <= '0;
            idx      <= '0;
            band     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.cmd_next || bus.cmd_prev) begin
                sel   <= bus.cmd_next ? sel_next : sel_prev;
                state <= S_LOAD;
                // A second command during LOAD keeps the original play intent.
                if (state != S_LOAD) load_go <= running ? S_FETCH : S_STOP;
            end else begin
                if (running) begin
                    state <= nxt;
                    case (state)
                        S_FETCH: begin
                            if (!sample) begin
                                wait_cnt <= wait_cnt + 2'd1;
                            end else if (dur == 5'd0) begin
                                done    <= 1'b1;
                                addr    <= bus.song_base;
                                load_go <= S_FETCH;
                            end else begin
                                cnt  <= {23'd0, dur} * TPU - 28'd1;
                                idx  <= bus.rom_data[11:8];
                                band <= bus.rom_data[7:5];
                            end
                        end
                        S_PLAY: begin
                            if (cnt == GAP && GAP == 28'd0) begin
                                addr     <= addr + 16'd1;
                                wait_cnt <= '0;
                            end else begin
                                cnt <= cnt - 28'd1;
                            end
                        end
                        default: begin // S_GAP
                            if (cnt == 28'd0) begin
                                addr     <= addr + 16'd1;
                                wait_cnt <= '0;
                            end else begin
                                cnt <= cnt - 28'd1;
                            end
                        end
                    endcase
                end
                if (state == S_LOAD) begin
                    addr     <= bus.song_base;
                    state    <= load_go;
                    wait_cnt <= '0;
                end
                if (bus.cmd_play) begin
                    case (state)
                        S_STOP: begin
                            state    <= S_FETCH;
                            wait_cnt <= '0;
                        end
                        S_FETCH, S_PLAY, S_GAP: begin
                            saved <= nxt;
                            state <= S_PAUSE;
                        end
                        S_PAUSE: state <= saved;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.rom_addr   = addr;
    assign bus.song_sel   = sel;
    assign bus.note_idx   = idx;
    assign bus.note_band  = band;
    assign bus.song_done  = done;
    assign bus.playing    = running;
    assign bus.note_valid = (state == S_PLAY) && (idx != 4'd0);
endmodule

// File: tb/tb_song_scheduler.sv
module tb_song_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [11:0] rom [64];

    song_scheduler_if #(.SONG_W(3)) bus ();

    song_scheduler #(
        .TICKS_PER_UNIT(4),
        .GAP_TICKS(1),
        .ROM_LAT(1),
        .SONG_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Score ROM with one cycle of latency; each song starts at song_sel*16.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[5:0]];
    assign bus.song_base = {9'd0, bus.song_sel, 4'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit nx, input bit pv, input bit pl);
        bus.cmd_next = nx;
        bus.cmd_prev = pv;
        bus.cmd_play = pl;
        @(negedge clk);
        bus.cmd_next = 1'b0;
        bus.cmd_prev = 1'b0;
        bus.cmd_play = 1'b0;
    endtask

    // kind 0 waits for note_valid, kind 1 for song_done; a timeout is a failure.
    task automatic wait_hi(input string tag, input int kind, input int lim);
        int g = 0;
        while (((kind == 0) ? bus.note_valid : bus.song_done) !== 1'b1 && g < lim) begin
            @(negedge clk);
            g++;
        end
        chk(tag, 32'(g < lim), 32'd1);
    endtask

    initial begin
        int c;
        int v;
        int g;
        for (int i = 0; i < 64; i++) rom[i] = 12'h000;
        rom[0]  = 12'h3A2;   // idx3 band5 dur2
        rom[1]  = 12'h004;   // rest, dur4
        rom[2]  = 12'h000;   // end marker
        rom[16] = 12'h5E1;
        rom[17] = 12'h000;
        rom[32] = 12'h7C3;   // idx7 band6 dur3
        rom[33] = 12'h000;
        bus.cmd_play = 1'b0; bus.cmd_next = 1'b0; bus.cmd_prev = 1'b0;
        bus.repeat_mode = 1'b0;
        bus.song_last = 3'd2;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        chk("rst_sel", 32'(bus.song_sel), 0);
        chk("rst_out", 32'({bus.note_valid, bus.playing, bus.song_done, bus.note_idx, bus.note_band}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: first note, timing from FETCH entry
        pulse(0, 0, 1);
        chk("t1_playing", 32'(bus.playing), 1);
        chk("t1_fetch0", 32'(bus.note_valid), 0);
        @(negedge clk);
        chk("t1_fetch1", 32'(bus.note_valid), 0);
        @(negedge clk);
        chk("t1_valid_start", 32'(bus.note_valid), 1);
        chk("t1_idx_band", 32'({bus.note_idx, bus.note_band}), 32'({4'd3, 3'd5}));
        c = 0; g = 0;
        while (bus.note_valid === 1'b1 && g < 30) begin c++; g++; @(negedge clk); end
        chk("t1_valid_len", 32'(c), 7);
        chk("t1_gap_addr", 32'(bus.rom_addr), 0);
        chk("t1_gap_idx", 32'(bus.note_idx), 3);
        @(negedge clk);
        chk("t1_addr_adv", 32'(bus.rom_addr), 1);

        // 2: rest word, 2 fetch + 16 silent cycles at address 1
        c = 0; v = 0; g = 0;
        while (bus.rom_addr === 16'd1 && g < 60) begin
            c++; g++;
            if (bus.note_valid === 1'b1) v++;
            @(negedge clk);
        end
        chk("t2_rest_cycles", 32'(c), 18);
        chk("t2_rest_silent", 32'(v), 0);
        chk("t2_addr", 32'(bus.rom_addr), 2);

        // 3: end marker, no repeat
        wait_hi("t3_done_wait", 1, 20);
        chk("t3_stop", 32'(bus.playing), 0);
        chk("t3_base", 32'(bus.rom_addr), 0);
        @(negedge clk);
        chk("t3_done_pulse", 32'(bus.song_done), 0);
        chk("t3_still_stop", 32'(bus.playing), 0);

        // 3b: repeat restarts from song_base
        bus.repeat_mode = 1'b1;
        pulse(0, 0, 1);
        wait_hi("t3r_done_wait", 1, 100);
        chk("t3r_base", 32'(bus.rom_addr), 0);
        @(negedge clk);
        chk("t3r_playing", 32'(bus.playing), 1);
        chk("t3r_done_pulse", 32'(bus.song_done), 0);
        bus.repeat_mode = 1'b0;

        // 5: pause mid-note keeps the total valid length
        wait_hi("t5_valid_wait", 0, 10);
        c = 1;
        @(negedge clk); if (bus.note_valid === 1'b1) c++;
        @(negedge clk); if (bus.note_valid === 1'b1) c++;
        pulse(0, 0, 1);
        chk("t5_pause_valid", 32'(bus.note_valid), 0);
        chk("t5_pause_playing", 32'(bus.playing), 0);
        v = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.note_valid === 1'b1) v++;
            @(negedge clk);
        end
        chk("t5_paused_silent", 32'(v), 0);
        pulse(0, 0, 1);
        g = 0;
        while (bus.note_valid === 1'b1 && g < 30) begin c++; g++; @(negedge clk); end
        chk("t5_total_valid", 32'(c), 7);
        wait_hi("t5_done_wait", 1, 100);
        @(negedge clk);
        chk("t5_stopped", 32'(bus.playing), 0);

        // 4: song select while stopped, then while playing
        pulse(1, 0, 0);
        chk("t4_next_sel", 32'(bus.song_sel), 1);
        @(negedge clk);
        chk("t4_next_base", 32'(bus.rom_addr), 16);
        chk("t4_next_stop", 32'(bus.playing), 0);
        pulse(1, 0, 0);
        chk("t4_sel2", 32'(bus.song_sel), 2);
        @(negedge clk);
        chk("t4_base2", 32'(bus.rom_addr), 32);
        pulse(0, 0, 1);
        wait_hi("t4_valid_wait", 0, 10);
        chk("t4_idx_band", 32'({bus.note_idx, bus.note_band}), 32'({4'd7, 3'd6}));
        pulse(1, 0, 0);
        chk("t4_wrap_sel", 32'(bus.song_sel), 0);
        chk("t4_load_silent", 32'(bus.note_valid), 0);
        @(negedge clk);
        chk("t4_wrap_base", 32'(bus.rom_addr), 0);
        chk("t4_wrap_playing", 32'(bus.playing), 1);
        pulse(0, 1, 0);
        chk("t4_prev_sel", 32'(bus.song_sel), 2);
        @(negedge clk);
        chk("t4_prev_base", 32'(bus.rom_addr), 32);
        chk("t4_prev_playing", 32'(bus.playing), 1);

        // 6: next beats play in the same cycle, then reset mid-note
        pulse(1, 0, 1);
        chk("t6_sel", 32'(bus.song_sel), 0);
        @(negedge clk);
        chk("t6_no_pause", 32'(bus.playing), 1);
        chk("t6_base", 32'(bus.rom_addr), 0);
        wait_hi("t6_valid_wait", 0, 10);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_addr_sel", 32'({bus.rom_addr, 13'd0, bus.song_sel}), 0);
        chk("t6_rst_out", 32'({bus.note_valid, bus.playing, bus.song_done, bus.note_idx, bus.note_band}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_after_rst", 32'(bus.playing), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
